// File: rtl/tlc_pkg.sv
// Light codes, FSM state type and table-field helper shared by the phase sequencer.
package tlc_pkg;

  localparam logic [1:0] LT_GREEN  = 2'd0;
  localparam logic [1:0] LT_YELLOW = 2'd1;
  localparam logic [1:0] LT_RED    = 2'd2;

  // Widest per-phase table bus the helper accepts (16 phases x 32 bits).
  localparam int MAX_BUS_W = 512;

  typedef enum logic [1:0] {
    GREEN,
    YELLOW,
    ALLRED
  } tlc_state_t;

  function automatic logic [31:0] green_field(input logic [MAX_BUS_W-1:0] bus,
                                              input int idx,
                                              input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return 32'(bus >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/tlc_next_phase.sv
// Round-robin demand picker: first phase after i_current with demand (wrapping to
// i_current itself), or plain i_current+1 when skipping is off or nothing is requested.
module tlc_next_phase #(
  parameter int NUM_PHASES = 3,
  parameter int PH_W       = 2
) (
  input  logic [PH_W-1:0]       i_current,
  input  logic [NUM_PHASES-1:0] i_demand,
  input  logic                  i_skip_en,
  output logic [PH_W-1:0]       o_next
);

  localparam int CW = PH_W + 1;

  logic [CW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    o_next  = (int'(i_current) + 1 >= NUM_PHASES) ? '0 : i_current + PH_W'(1);
    if (i_skip_en) begin
      for (int k = 1; k <= NUM_PHASES; k++) begin
        w_cand = {1'b0, i_current} + CW'(k);
        if (int'(w_cand) >= NUM_PHASES) begin
          w_cand = w_cand - CW'(NUM_PHASES);
        end
        if (!w_found && |(i_demand & (NUM_PHASES'(1) << w_cand))) begin
          o_next  = w_cand[PH_W-1:0];
          w_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tlc_phase_sequencer.sv
// N-phase traffic-light sequencer: each served phase runs GREEN, YELLOW, ALLRED with a
// per-phase green length from the peak/off-peak tables; all outputs registered.
module tlc_phase_sequencer
  import tlc_pkg::*;
#(
  parameter int NUM_PHASES = 3,
  parameter int TIMER_W    = 8,
  parameter int YELLOW_T   = 4,
  parameter int ALLRED_T   = 4,
  parameter int PH_W       = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          peak,
  input  logic [NUM_PHASES*TIMER_W-1:0] green_peak,
  input  logic [NUM_PHASES*TIMER_W-1:0] green_off,
  input  logic [NUM_PHASES-1:0]         demand,
  input  logic                          skip_en,
  output logic [2*NUM_PHASES-1:0]       light,
  output logic [PH_W-1:0]               active_phase,
  output logic                          cycle_done
);

  if (NUM_PHASES < 2 || NUM_PHASES > 16 || (2 ** PH_W) < NUM_PHASES) begin : g_bad_phases
    $error("tlc_phase_sequencer: NUM_PHASES must be 2..16 and fit in PH_W");
  end
  if (TIMER_W < 1 || TIMER_W > 30 || NUM_PHASES * TIMER_W > MAX_BUS_W) begin : g_bad_timer
    $error("tlc_phase_sequencer: TIMER_W out of range");
  end
  if (YELLOW_T < 1 || YELLOW_T >= (2 ** TIMER_W) ||
      ALLRED_T < 1 || ALLRED_T >= (2 ** TIMER_W)) begin : g_bad_durations
    $error("tlc_phase_sequencer: YELLOW_T/ALLRED_T must be >=1 and fit in TIMER_W");
  end

  localparam logic [TIMER_W-1:0] YEL_LAST = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] AR_LAST  = TIMER_W'(ALLRED_T - 1);

  tlc_state_t                    r_state;
  logic [TIMER_W-1:0]            r_timer;
  logic [TIMER_W-1:0]            r_glen;
  logic [PH_W-1:0]               r_phase;
  logic [2*NUM_PHASES-1:0]       r_light;
  logic                          r_done;

  logic [PH_W-1:0]               w_next;
  logic [PH_W-1:0]               w_load_idx;
  logic [NUM_PHASES*TIMER_W-1:0] w_green_bus;
  logic [TIMER_W-1:0]            w_field;
  logic [TIMER_W-1:0]            w_glen;

  tlc_next_phase #(
    .NUM_PHASES (NUM_PHASES),
    .PH_W       (PH_W)
  ) u_next_phase (
    .i_current (r_phase),
    .i_demand  (demand),
    .i_skip_en (skip_en),
    .o_next    (w_next)
  );

  // Mode and table are only looked at where a green begins (reset or last ALLRED
  // cycle); the resolved length then lives in r_glen, which acts as the mode latch.
  assign w_load_idx  = reset ? w_next : '0;
  assign w_green_bus = peak ? green_peak : green_off;
  assign w_field     = TIMER_W'(green_field(MAX_BUS_W'(w_green_bus), int'(w_load_idx), TIMER_W));
  assign w_glen      = (w_field == '0) ? TIMER_W'(1) : w_field;

  function automatic logic [2*NUM_PHASES-1:0] f_lights(input logic [PH_W-1:0] idx,
                                                       input logic [1:0]      code);
    logic [2*NUM_PHASES-1:0] v;
    v = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      v[2*p +: 2] = (PH_W'(p) == idx) ? code : LT_RED;
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= GREEN;
      r_timer <= '0;
      r_phase <= '0;
      r_glen  <= w_glen;
      r_light <= f_lights('0, LT_GREEN);
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        GREEN: begin
          if (r_timer == r_glen - TIMER_W'(1)) begin
            r_state <= YELLOW;
            r_timer <= '0;
            r_light <= f_lights(r_phase, LT_YELLOW);
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        YELLOW: begin
          if (r_timer == YEL_LAST) begin
            r_state <= ALLRED;
            r_timer <= '0;
            r_light <= f_lights(r_phase, LT_RED);
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        ALLRED: begin
          if (r_timer == AR_LAST) begin
            r_state <= GREEN;
            r_timer <= '0;
            r_phase <= w_next;
            r_glen  <= w_glen;
            r_light <= f_lights(w_next, LT_GREEN);
            r_done  <= 1'b1;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        default: begin
          r_state <= ALLRED;
          r_timer <= '0;
          r_light <= f_lights(r_phase, LT_RED);
        end
      endcase
    end
  end

  assign light        = r_light;
  assign active_phase = r_phase;
  assign cycle_done   = r_done;

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Bench for tlc_phase_sequencer: expected greens (phase, length) are queued per scenario
// and matched against green runs decoded from the light outputs, plus per-cycle checks.
`timescale 1ns/1ps
module tb_tlc_phase_sequencer;
  import tlc_pkg::*;

  localparam int NP = 3;
  localparam int TW = 8;
  localparam int YT = 4;
  localparam int AT = 4;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            peak = 1'b0;
  logic            skip_en = 1'b0;
  logic [NP*TW-1:0] green_peak;
  logic [NP*TW-1:0] green_off;
  logic [NP-1:0]   demand = '0;
  logic [2*NP-1:0] light;
  logic [PW-1:0]   active_phase;
  logic            cycle_done;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    int ph;
    int len;
  } exp_t;
  exp_t exp_q[$];

  // monitor state: kind 0 green, 1 yellow, 2 all-red, 3 nothing yet
  int   m_prev_kind = 3;
  int   m_prev_ph   = 0;
  int   m_run       = 0;
  exp_t m_e;

  always #5 clk = ~clk;

  tlc_phase_sequencer #(
    .NUM_PHASES (NP),
    .TIMER_W    (TW),
    .YELLOW_T   (YT),
    .ALLRED_T   (AT),
    .PH_W       (PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .peak         (peak),
    .green_peak   (green_peak),
    .green_off    (green_off),
    .demand       (demand),
    .skip_en      (skip_en),
    .light        (light),
    .active_phase (active_phase),
    .cycle_done   (cycle_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NP*TW-1:0] pack(input int g0, input int g1, input int g2);
    return {TW'(g2), TW'(g1), TW'(g0)};
  endfunction

  function automatic logic [2*NP-1:0] lights_exp(input int ph, input logic [1:0] code);
    logic [2*NP-1:0] v;
    for (int i = 0; i < NP; i++) v[2*i +: 2] = (i == ph) ? code : LT_RED;
    return v;
  endfunction

  task automatic push(input int ph, input int len);
    exp_t e;
    e.ph  = ph;
    e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check_reset();
    @(negedge clk);
    chk("rst_light", light, lights_exp(0, LT_GREEN));
    chk("rst_phase", active_phase, 0);
    chk("rst_done", cycle_done, 0);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    int nonred;
    int n3;
    int ph;
    int kind;
    logic [1:0] c;
    if (!reset) begin
      m_prev_kind = 3;
      m_run       = 0;
    end else begin
      nonred = 0; n3 = 0; ph = 0; kind = 2;
      for (int i = 0; i < NP; i++) begin
        c = light[2*i +: 2];
        if (c == 2'd3) n3++;
        if (c != LT_RED) begin
          nonred++;
          ph   = i;
          kind = int'(c);
        end
      end
      chk("inv_one_active", nonred <= 1, 1);
      chk("inv_no_code3", n3, 0);
      chk("cycle_done", cycle_done, (m_prev_kind == 2 && kind == 0));
      if (kind != 2) chk("active_phase", active_phase, ph);
      if (m_prev_kind != 3 && kind == m_prev_kind && (kind == 2 || ph == m_prev_ph)) begin
        m_run++;
      end else begin
        if (m_prev_kind == 0 && exp_q.size() > 0) begin
          m_e = exp_q.pop_front();
          chk("green_phase", m_prev_ph, m_e.ph);
          chk("green_len", m_run, m_e.len);
        end
        if (m_prev_kind == 1) chk("yellow_len", m_run, YT);
        if (m_prev_kind == 2) chk("allred_len", m_run, AT);
        m_run = 1;
      end
      m_prev_kind = kind;
      m_prev_ph   = ph;
    end
  end

  initial begin
    green_off  = pack(16, 16, 8);
    green_peak = pack(32, 32, 16);
    repeat (2) @(posedge clk);

    // off-peak rotation
    do_reset();
    push(0, 16); push(1, 16); push(2, 8); push(0, 16);
    check_reset();
    wait_drain(200);

    // peak rotation
    peak = 1'b1;
    do_reset();
    push(0, 32); push(1, 32); push(2, 16);
    check_reset();
    wait_drain(300);

    // mode and table change mid-green only affect later greens
    peak = 1'b0;
    do_reset();
    push(0, 16); push(1, 32); push(2, 16);
    repeat (5) @(posedge clk);
    #1 peak = 1'b1;
    green_off = pack(40, 16, 8);
    wait_drain(300);
    green_off = pack(16, 16, 8);

    // demand skip, including wrap back to the current phase
    peak    = 1'b0;
    skip_en = 1'b1;
    demand  = 3'b100;
    do_reset();
    push(0, 16); push(2, 8); push(2, 8);
    wait_drain(300);
    demand = 3'b000;
    do_reset();
    push(0, 16); push(1, 16); push(2, 8); push(0, 16);
    wait_drain(300);

    // reset during yellow restarts phase 0 green with a full length
    skip_en = 1'b0;
    do_reset();
    push(0, 16);
    wait_drain(100);
    do_reset();
    push(0, 16); push(1, 16);
    check_reset();
    wait_drain(200);

    // zero-length fields give one-cycle greens
    green_off = pack(0, 3, 0);
    do_reset();
    push(0, 1); push(1, 3); push(2, 1); push(0, 1);
    wait_drain(200);

    // random demand/mode soak for the safety invariant
    green_off  = pack(2, 5, 1);
    green_peak = pack(3, 0, 4);
    do_reset();
    repeat (10000) begin
      @(posedge clk);
      #1;
      demand = NP'($urandom);
      peak   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) skip_en = ~skip_en;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/tlc_phase_sequencer.md
Name: tlc_phase_sequencer

Overview:
- Parametrised N-phase traffic-light sequencer and next-generation intersection controller.
- Cycles phases through GREEN, YELLOW and ALL-RED clearance, with per-phase green durations for peak and off-peak modes.
- Optionally skips phases with no sensor demand.
- Drives one 2-bit light code per phase to the pad/display logic.

Parameters:
- NUM_PHASES, 3, number of conflicting signal phases (2..16).
- TIMER_W, 8, width of the cycle timer and of each green-time field.
- YELLOW_T, 4, yellow duration in clk cycles (>=1).
- ALLRED_T, 4, all-red clearance duration in clk cycles (>=1).
- PH_W, 2, width of the phase index; must satisfy 2^PH_W >= NUM_PHASES.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-low reset.
- peak, in, 1, 1 = peak mode, 0 = off-peak mode.
- green_peak, in, NUM_PHASES*TIMER_W, per-phase green cycles in peak mode; phase i occupies bits [i*TIMER_W +: TIMER_W].
- green_off, in, NUM_PHASES*TIMER_W, per-phase green cycles in off-peak mode; same packing.
- demand, in, NUM_PHASES, per-phase sensor demand, level-sensitive.
- skip_en, in, 1, 1 = skip phases without demand.
- light, out, 2*NUM_PHASES, per-phase code: 0 = green, 1 = yellow, 2 = red; 3 is never driven.
- active_phase, out, PH_W, index of the phase currently served.
- cycle_done, out, 1, one-cycle pulse at the end of each ALL-RED interval.

Behaviour:
- Interface as decided: clock clk; reset is named reset, synchronous, active-low.
- All outputs are registered.
- Reset (reset==0 at a clk edge):
  - state = GREEN, active_phase = 0, timer = 0.
  - light = phase 0 code 0, all other phases code 2.
  - cycle_done = 0.
  - The mode latch captures peak.
- Reset asserted mid-operation aborts any interval immediately. No yellow or clearance is emitted.
- FSM states: GREEN, YELLOW, ALLRED. A single timer counts from 0 and clears on every state change.
- GREEN:
  - The active phase shows 0; all others show 2.
  - Green length G is taken from the latched mode: green_peak or green_off, field [active_phase].
  - G==0 is treated as 1.
  - Leave GREEN when timer == G-1, so the phase is green for exactly G cycles.
- YELLOW:
  - The active phase shows 1.
  - Leave YELLOW when timer == YELLOW_T-1.
- ALLRED:
  - Every phase shows 2.
  - When timer == ALLRED_T-1: pulse cycle_done, load active_phase with next_phase, enter GREEN.
  - On that same edge, latch peak for the new green.
- Mode latching: peak is sampled only on GREEN entry. A mode change during an interval does not alter the current green.
- Green-time latching: the green_peak/green_off field is latched at GREEN entry as well. Later changes apply from the next green.
- next_phase with skip_en==0: (active_phase+1) mod NUM_PHASES.
- next_phase with skip_en==1:
  - Search round-robin from active_phase+1 for the first phase with demand set, including wrapping back to the current phase.
  - If no demand bit is set anywhere, use (active_phase+1) mod NUM_PHASES.
- next_phase is evaluated from demand on the final ALLRED cycle.
- Safety invariant: at most one phase has a code other than 2 in any cycle; the code of every non-active phase is always 2.
- Timer width: the timer never wraps; maximum count is max(G, YELLOW_T, ALLRED_T)-1 < 2^TIMER_W. YELLOW_T and ALLRED_T must fit in TIMER_W; this is checked at elaboration.
- Full cycle length: G + YELLOW_T + ALLRED_T cycles per served phase.

Decomposition:
- Package tlc_pkg holds:
  - light codes LT_GREEN=2'd0, LT_YELLOW=2'd1, LT_RED=2'd2.
  - state enum tlc_state_t {GREEN, YELLOW, ALLRED}.
  - a green-field extract function.
- One sub-module: tlc_next_phase, a combinational round-robin demand picker.
  - Parameters: NUM_PHASES, PH_W.
  - Inputs: current, demand, skip_en.
  - Output: next index.
- The FSM, timer and latches stay in tlc_phase_sequencer.

Test Plan:
All scenarios use NUM_PHASES=3, YELLOW_T=4, ALLRED_T=4.
- Reset and off-peak cycle. Stimulus: skip_en=0; green_off fields = 16, 16, 8. Required response:
  - Phase 0 is green for cycles 1-16 after reset, yellow for 4 cycles, then all-red for 4 cycles.
  - cycle_done pulses once; phase 1 then goes green.
  - Phase 2 is green for 8 cycles; active_phase sequence is 0, 1, 2, 0.
- Peak mode. Stimulus: peak=1; green_peak = 32, 32, 16. Required response: greens last 32, 32, 16 cycles.
- Mode toggle. Stimulus: toggle peak mid-green of phase 0. Required response: the current green keeps its original length; the new length applies from the next green.
- Demand skip. Stimulus: skip_en=1, demand=3'b100 while phase 0 is green. Required response: next green is phase 2. With demand=3'b000, next green is phase 1.
- Mid-operation reset. Stimulus: reset=0 for 1 cycle during a yellow. Required response: the next cycle shows phase 0 green, others red, timer 0, and no yellow.
- Edge cases and invariant. Stimulus: a green field of 0. Required response:
  - A green field of 0 gives a 1-cycle green.
  - An assertion checks that no two phases are ever non-red at once and that code 3 never appears, across 10k cycles of random demand/peak.
